// File: rtl/norm_pkg.sv
// Shared definitions for the normalization shifter: default widths, FSM states
// and the fixed number of shift steps per operation.
package norm_pkg;

    localparam int W_DEF  = 55;
    localparam int SW_DEF = 6;
    localparam int EW_DEF = 11;
    localparam int STEPS  = SW_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/norm_shift_step.sv
// One conditional left shift by 2^k with zero fill; reused for every step of
// the iterative normalization.
module norm_shift_step
    import norm_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int KW = 3
) (
    input  logic [W-1:0]  din,
    input  logic [KW-1:0] k,
    input  logic          en,
    output logic [W-1:0]  dout
);

    logic [31:0] amt;

    assign amt  = 32'd1 << k;
    assign dout = en ? (din << amt) : din;

endmodule

// File: rtl/norm_shift_unit.sv
// Iterative left-normalization shifter: shifts the significand by S one binary
// step per cycle (32,16,...,1) and returns exp - S saturated at zero.
// Optional build macro NORM_RANGE_CHECK_EN flags counts above W-1 via err_o.
module norm_shift_unit
    import norm_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int SW = SW_DEF,
    parameter int EW = EW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [SW-1:0] shift_i,
    input  logic [W-1:0]  data_i,
    input  logic [EW-1:0] exp_i,
    output logic          valid_o,
    input  logic          ack_i,
    output logic [W-1:0]  data_o,
    output logic [EW-1:0] exp_o,
    output logic          unf_o,
    output logic          err_o
);

    localparam int KBITS = (SW > 1) ? $clog2(SW) : 1;

    function automatic logic [EW-1:0] sat_exp(input logic signed [EW:0] d);
        return d[EW] ? '0 : d[EW-1:0];
    endfunction

    state_t             state_q, state_d;
    logic [KBITS-1:0]   k_q;
    logic               cap;
    logic               last_step;

    logic [W-1:0]       data_p0;
    logic [SW-1:0]      s_p0;
    logic [EW-1:0]      exp_p0;
    logic               unf_p0;
    logic [W-1:0]       step_out;

    logic signed [EW:0] diff_c;

    logic [W-1:0]       res_data_c;
    logic [EW-1:0]      res_exp_c;
    logic               res_unf_c;
    logic               res_err_c;

    assign cap       = (state_q == IDLE) && valid_i;
    assign last_step = (state_q == SHIFT) && (k_q == '0);
    assign ready_o   = (state_q == IDLE);
    assign valid_o   = (state_q == DONE);

    assign diff_c = $signed({1'b0, exp_i}) - $signed({{(EW + 1 - SW){1'b0}}, shift_i});

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i) state_d = SHIFT;
            SHIFT:   if (k_q == '0) state_d = DONE;
            DONE:    if (ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            if (cap)
                k_q <= KBITS'(SW - 1);
            else if (state_q == SHIFT)
                k_q <= k_q - KBITS'(1);
        end
    end

    // stage p0: operands captured, exponent resolved; working word shifts in place
    always_ff @(posedge clk) begin
        if (cap) begin
            data_p0 <= data_i;
            s_p0    <= shift_i;
            exp_p0  <= sat_exp(diff_c);
            unf_p0  <= diff_c[EW];
        end else if (state_q == SHIFT) begin
            data_p0 <= step_out;
        end
    end

    norm_shift_step #(
        .W  (W),
        .KW (KBITS)
    ) u_step (
        .din  (data_p0),
        .k    (k_q),
        .en   (s_p0[k_q]),
        .dout (step_out)
    );

`ifdef NORM_RANGE_CHECK_EN
    logic          range_p0;
    logic [EW-1:0] exp_in_p0;

    always_ff @(posedge clk) begin
        if (cap) begin
            range_p0  <= (shift_i > SW'(W - 1));
            exp_in_p0 <= exp_i;
        end
    end

    // an out-of-range count still runs all steps so the latency stays fixed
    assign res_data_c = range_p0 ? '0 : step_out;
    assign res_exp_c  = range_p0 ? exp_in_p0 : exp_p0;
    assign res_unf_c  = range_p0 ? 1'b0 : unf_p0;
    assign res_err_c  = range_p0;
`else
    assign res_data_c = step_out;
    assign res_exp_c  = exp_p0;
    assign res_unf_c  = unf_p0;
    assign res_err_c  = 1'b0;
`endif

    // stage p1: result registers, loaded on the final step and held through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o <= '0;
            exp_o  <= '0;
            unf_o  <= 1'b0;
            err_o  <= 1'b0;
        end else if (last_step) begin
            data_o <= res_data_c;
            exp_o  <= res_exp_c;
            unf_o  <= res_unf_c;
            err_o  <= res_err_c;
        end
    end

endmodule

// File: tb/tb_norm_shift_unit.sv
// Directed bench for norm_shift_unit with an arithmetic reference model and
// per-cycle output comparison.
module tb_norm_shift_unit;

    localparam int W  = 55;
    localparam int SW = 6;
    localparam int EW = 11;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          valid_i = 1'b0;
    logic          ack_i   = 1'b1;
    logic [SW-1:0] shift_i = '0;
    logic [W-1:0]  data_i  = '0;
    logic [EW-1:0] exp_i   = '0;
    logic          ready_o;
    logic          valid_o;
    logic [W-1:0]  data_o;
    logic [EW-1:0] exp_o;
    logic          unf_o;
    logic          err_o;

    norm_shift_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .shift_i (shift_i),
        .data_i  (data_i),
        .exp_i   (exp_i),
        .valid_o (valid_o),
        .ack_i   (ack_i),
        .data_o  (data_o),
        .exp_o   (exp_o),
        .unf_o   (unf_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  d;
        logic [EW-1:0] e;
        logic          u;
        logic          r;
        int            id;
    } res_t;

    function automatic res_t model(input logic [W-1:0] d, input logic [SW-1:0] s,
                                   input logic [EW-1:0] e);
        res_t m;
        int   diff;
        m.d  = d << s;
        diff = int'(e) - int'(s);
        m.u  = (diff < 0);
        m.e  = m.u ? '0 : EW'(diff);
        m.r  = 1'b0;
        m.id = 0;
`ifdef NORM_RANGE_CHECK_EN
        if (int'(s) > W - 1) begin
            m.d = '0;
            m.e = e;
            m.u = 1'b0;
            m.r = 1'b1;
        end
`endif
        return m;
    endfunction

    // reference timeline: busy from accept until the ack edge, result due 6 edges after accept
    int   cyc  = 0;
    int   acc  = 0;
    int   opn  = 0;
    logic busy = 1'b0;
    logic was_busy;
    logic ev_pre;
    res_t cur;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 1'b0;
        end else begin
            was_busy = busy;
            ev_pre   = busy && (cyc - acc >= 6);
            if (ev_pre && ack_i) busy = 1'b0;
            cyc = cyc + 1;
            if (!was_busy && valid_i) begin
                busy   = 1'b1;
                acc    = cyc;
                cur    = model(data_i, shift_i, exp_i);
                cur.id = opn;
                opn    = opn + 1;
            end
        end
    end

    // hand-computed expectations for selected operations, indexed by op number
    logic          pin_en   [16];
    logic [W-1:0]  pin_data [16];
    logic [EW-1:0] pin_exp  [16];
    logic          pin_unf  [16];
    logic          pin_err  [16];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    logic ev;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", 64'(ready_o), 64'd1);
            chk("rst_valid", 64'(valid_o), 64'd0);
            chk("rst_data",  64'(data_o),  64'd0);
            chk("rst_exp",   64'(exp_o),   64'd0);
            chk("rst_unf",   64'(unf_o),   64'd0);
            chk("rst_err",   64'(err_o),   64'd0);
        end else begin
            ev = busy && (cyc - acc >= 6);
            chk("ready", 64'(ready_o), 64'(!busy));
            chk("valid", 64'(valid_o), 64'(ev));
            if (ev) begin
                chk("data", 64'(data_o), 64'(cur.d));
                chk("exp",  64'(exp_o),  64'(cur.e));
                chk("unf",  64'(unf_o),  64'(cur.u));
                chk("err",  64'(err_o),  64'(cur.r));
                if (cur.id < 16 && pin_en[cur.id] === 1'b1) begin
                    chk("pin_data", 64'(data_o), 64'(pin_data[cur.id]));
                    chk("pin_exp",  64'(exp_o),  64'(pin_exp[cur.id]));
                    chk("pin_unf",  64'(unf_o),  64'(pin_unf[cur.id]));
                    chk("pin_err",  64'(err_o),  64'(pin_err[cur.id]));
                end
            end
        end
    end

    task automatic pin(input int idx, input logic [W-1:0] d, input logic [EW-1:0] e,
                       input logic u, input logic r);
        pin_en[idx]   = 1'b1;
        pin_data[idx] = d;
        pin_exp[idx]  = e;
        pin_unf[idx]  = u;
        pin_err[idx]  = r;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_o) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 50) begin
                $display("FAIL ready_wait actual=%0b required=1", ready_o);
                $fatal(1, "ready_o timeout");
            end
        end
    endtask

    task automatic issue(input logic [W-1:0] d, input logic [SW-1:0] s, input logic [EW-1:0] e);
        wait_ready();
        data_i  = d;
        shift_i = s;
        exp_i   = e;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    initial begin
        int n;
        logic [W-1:0] one;
        for (int i = 0; i < 16; i++) pin_en[i] = 1'b0;
        one = 55'd1;

        pin(0, one << 54, 11'd979, 1'b0, 1'b0);
        pin(1, one << 54, 11'd100, 1'b0, 1'b0);
        pin(2, one << 50, 11'd0,   1'b1, 1'b0);
`ifdef NORM_RANGE_CHECK_EN
        pin(3, '0, 11'd200, 1'b0, 1'b1);
        pin(9, '0, 11'd2000, 1'b0, 1'b1);
`else
        pin(3, '0, 11'd140, 1'b0, 1'b0);
        pin(9, '0, 11'd1945, 1'b0, 1'b0);
`endif
        pin(4, 55'h91A0,   11'd47, 1'b0, 1'b0);
        pin(5, 55'hABC000, 11'd0,  1'b0, 1'b0);
        pin(7, 55'd2,      11'd9,  1'b0, 1'b0);
        pin(8, one << 54,  11'd0,  1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(one << 10, 6'd44, 11'd1023);
        issue(one << 54, 6'd0,  11'd100);
        issue(one << 20, 6'd30, 11'd5);
        issue(55'h7,     6'd60, 11'd200);

        // result held while ack_i is low; valid_i pulses must be ignored
        issue(55'h1234, 6'd3, 11'd50);
        ack_i = 1'b0;
        n = 0;
        while (!valid_o) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 20) begin
                $display("FAIL valid_wait actual=%0b required=1", valid_o);
                $fatal(1, "valid_o timeout");
            end
        end
        for (int i = 0; i < 5; i++) begin
            valid_i = (i % 2 == 0);
            data_i  = W'({$urandom, $urandom});
            shift_i = 6'd7;
            exp_i   = 11'd3;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        ack_i   = 1'b1;

        issue(55'h0ABC, 6'd12, 11'd12);

        // reset during the third SHIFT cycle discards the operation
        issue(55'hFF, 6'd5, 11'd300);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(55'd1, 6'd1, 11'd10);
        issue(55'd1, 6'd54, 11'd54);
        issue({W{1'b1}}, 6'd55, 11'd2000);

        for (int i = 0; i < 3; i++)
            issue(W'({$urandom, $urandom}), SW'($urandom_range(0, 63)), EW'($urandom));

        wait_ready();
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
